// File: rtl/pipe_wb_stage.sv
// MEM->WB pipeline stage: one regfile write per transfer, valid/ready handshake, stall, flush,
// x0-write suppression. Define PIPE_WB_SKID_EN to add a skid slot that registers in_ready.
module pipe_wb_stage #(
  parameter int              DW        = 32,
  parameter int              AW        = 5,
  parameter logic [DW-1:0]   RST_DATA  = {DW{1'b0}},
  parameter bit              ZERO_SUPP = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stop,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_we,
  input  logic [AW-1:0] in_waddr,
  input  logic [DW-1:0] in_wdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_we,
  output logic [AW-1:0] out_waddr,
  output logic [DW-1:0] out_wdata,
  output logic [1:0]    occ
);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } ent_t;

  localparam ent_t RST_ENT = '{we: 1'b0, waddr: '0, wdata: RST_DATA};

  ent_t in_ent;
  ent_t m;
  logic m_v;
  logic in_fire;
  logic out_fire;

  assign in_ent   = '{we: in_we, waddr: in_waddr, wdata: in_wdata};
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  assign out_valid = m_v & ~stop;
  assign out_waddr = m.waddr;
  assign out_wdata = m.wdata;
  // x0 is hard-wired, so a write to it is dropped here rather than at the regfile
  assign out_we    = out_valid & m.we & ~(ZERO_SUPP & (m.waddr == '0));

`ifdef PIPE_WB_SKID_EN
  ent_t s;
  logic s_v;

  // Depends only on state: no combinational path from out_ready back upstream
  assign in_ready = ~rst & ~stop & ~s_v;
  assign occ      = {1'b0, m_v} + {1'b0, s_v};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
      m   <= RST_ENT;
      s   <= RST_ENT;
    end else if (flush) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
    end else if (!stop) begin
      if (out_fire && s_v) begin
        // in_ready was low, so nothing arrives while the skid drains into M
        m   <= s;
        s_v <= 1'b0;
      end else if (in_fire && (!m_v || out_fire)) begin
        m   <= in_ent;
        m_v <= 1'b1;
      end else if (in_fire) begin
        s   <= in_ent;
        s_v <= 1'b1;
      end else if (out_fire) begin
        m_v <= 1'b0;
      end
    end
  end
`else
  assign in_ready = ~rst & ~stop & (~m_v | out_ready);
  assign occ      = {1'b0, m_v};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_v <= 1'b0;
      m   <= RST_ENT;
    end else if (flush) begin
      m_v <= 1'b0;
    end else if (!stop) begin
      if (in_fire) begin
        m   <= in_ent;
        m_v <= 1'b1;
      end else if (out_fire) begin
        m_v <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_wb_stage.sv
// Randomized bench for pipe_wb_stage against a bounded-FIFO reference model.
// Two instances share inputs: default (ZERO_SUPP=1) and ZERO_SUPP=0 with a non-zero RST_DATA.
module tb_pipe_wb_stage;

`ifdef PIPE_WB_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam logic [31:0] RD1 = 32'hA5A5_5A5A;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } ent_t;

  logic clk = 1'b0;
  logic rst, stop, flush, in_valid, in_we, out_ready;
  logic [4:0]  in_waddr;
  logic [31:0] in_wdata;
  logic in_ready, out_valid, out_we;
  logic [4:0]  out_waddr;
  logic [31:0] out_wdata;
  logic [1:0]  occ;
  logic in_ready1, out_valid1, out_we1;
  logic [4:0]  out_waddr1;
  logic [31:0] out_wdata1;
  logic [1:0]  occ1;

  int n_chk = 0;
  int n_pass = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  pipe_wb_stage dut (
    .clk(clk), .rst(rst), .stop(stop), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_we(out_we), .out_waddr(out_waddr),
    .out_wdata(out_wdata), .occ(occ)
  );

  pipe_wb_stage #(.DW(32), .AW(5), .RST_DATA(RD1), .ZERO_SUPP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .stop(stop), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_we(in_we), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .out_valid(out_valid1), .out_ready(out_ready), .out_we(out_we1), .out_waddr(out_waddr1),
    .out_wdata(out_wdata1), .occ(occ1)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  // One clock: drive, check outputs against the model, then advance the model by the rules
  task automatic cycle(input logic iv, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ordy, input logic stp, input logic fl);
    logic e_ir, e_ov, e_we, e_we0;
    ent_t h;
    @(negedge clk);
    in_valid = iv; in_we = we; in_waddr = wa; in_wdata = wd;
    out_ready = ordy; stop = stp; flush = fl;
    #1;
    if (CAP == 2) e_ir = !stp && q.size() < 2;
    else          e_ir = !stp && (q.size() == 0 || ordy);
    e_ov = !stp && q.size() > 0;
    if (q.size() > 0) h = q[0];
    else h = '{we: 1'b0, waddr: 5'd0, wdata: 32'd0};
    e_we  = e_ov && h.we && h.waddr != 5'd0;
    e_we0 = e_ov && h.we;
    chk("in_ready", in_ready, e_ir);
    chk("in_ready0", in_ready1, e_ir);
    chk("out_valid", out_valid, e_ov);
    chk("out_we", out_we, e_we);
    chk("out_we_nozs", out_we1, e_we0);
    chk("occ", occ, q.size());
    chk("occ_cap", occ <= CAP, 1);
    if (q.size() > 0) begin
      chk("out_waddr", out_waddr, h.waddr);
      chk("out_wdata", out_wdata, h.wdata);
      chk("out_wdata0", out_wdata1, h.wdata);
    end
    if (fl) q.delete();
    else if (!stp) begin
      if (e_ov && ordy) void'(q.pop_front());
      if (iv && e_ir) q.push_back('{we: we, waddr: wa, wdata: wd});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; stop = 1'b0; flush = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_we", out_we, 0);
    chk("rst_out_waddr", out_waddr, 0);
    chk("rst_out_wdata", out_wdata, 32'd0);
    chk("rst_out_wdata0", out_wdata1, RD1);
    chk("rst_occ", occ, 0);
    chk("rst_in_ready", in_ready, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stop = 1'b0; flush = 1'b0; in_valid = 1'b0; in_we = 1'b0;
    in_waddr = '0; in_wdata = '0; out_ready = 1'b0;
    do_reset();

    // steady stream, downstream always ready
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 5'(i + 1), 32'h1000 + i, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);

    // write to x0
    cycle(1'b1, 1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);

    // back-pressure for 3 cycles, then drain
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 5'(3 + i), 32'h2000 + i, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);

    // stall 2 cycles with traffic on both sides, then resume
    cycle(1'b1, 1'b1, 5'd7, 32'h3000, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 5'd8, 32'h3001, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 5'd8, 32'h3001, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 5'(9 + i), 32'h3002 + i, 1'b1, 1'b0, 1'b0);

    // fill, then flush together with stop and a valid input
    cycle(1'b1, 1'b1, 5'd1, 32'h4000, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 5'd2, 32'h4001, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 5'd3, 32'h4002, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);

    // reset with an entry held
    cycle(1'b1, 1'b1, 5'd4, 32'h5000, 1'b0, 1'b0, 1'b0);
    do_reset();

    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(99) < 70, 1'($urandom),
            ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31)), $urandom,
            $urandom_range(99) < 60, $urandom_range(99) < 10, $urandom_range(99) < 5);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
